aes_stream_ctrl: RTL and testbench

Upstream command/framing stage for `aes_top`. Accepts a 32-bit valid/ready word stream carrying command packets (key load, encrypt, decrypt) and assembles 128/256-bit keys and 128-bit blocks. Drives `aes_top`'s single-cycle enables and holds its mode, key and block inputs. Captures `aes_out_blk` on `en_o` and returns each result as a 4-word output stream with backpressure.

---
 rtl/aes_stream_ctrl.sv | 136 +++++++++++++
 tb/tb_aes_stream_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: frames a 32-bit command stream into aes_top key/block loads and streams results back.
module aes_stream_ctrl #(
  parameter int KEY_S = 256,
  parameter int BLK_S = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  input  logic             in_tlast,
  output logic [31:0]      out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             out_tlast,
  output logic             en_cipher,
  output logic             en_decipher,
  output logic             en_key,
  output logic             aes128_mode,
  output logic             aes256_mode,
  output logic [KEY_S-1:0] aes_key,
  output logic [BLK_S-1:0] aes_in_blk,
  input  logic [BLK_S-1:0] aes_out_blk,
  input  logic             en_o,
  output logic             cmd_err
);
  typedef enum logic [2:0] {CMD, KEY_RX, BLK_RX, START, WAIT_CORE, TX, DRAIN} state_t;
  state_t state;
  logic [2:0] cnt, op;
  logic k256, key_valid, acc, last_word;
  logic [3:0] opc;
  logic [KEY_S-1:0] key_sh;
  logic [BLK_S-1:0] blk_sh, out_buf;
  assign acc = in_tvalid & in_tready;
  assign opc = in_tdata[3:0];
  assign last_word = cnt == ((state == KEY_RX && k256) ? 3'd7 : 3'd3);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CMD;
      cnt <= '0;
      op <= '0;
      k256 <= 1'b0;
      key_valid <= 1'b0;
      key_sh <= '0;
      blk_sh <= '0;
      out_buf <= '0;
      in_tready <= 1'b0;
      out_tdata <= '0;
      out_tvalid <= 1'b0;
      out_tlast <= 1'b0;
      en_cipher <= 1'b0;
      en_decipher <= 1'b0;
      en_key <= 1'b0;
      aes128_mode <= 1'b0;
      aes256_mode <= 1'b0;
      aes_key <= '0;
      aes_in_blk <= '0;
      cmd_err <= 1'b0;
    end else begin
      en_key <= 1'b0;
      en_cipher <= 1'b0;
      en_decipher <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        CMD: begin
          in_tready <= 1'b1;
          if (acc) begin
            cnt <= '0;
            op <= opc[2:0];
            k256 <= in_tdata[4];
            if (!in_tlast && opc == 4'h1) state <= KEY_RX;
            else if (!in_tlast && (opc == 4'h2 || opc == 4'h4) && key_valid) state <= BLK_RX;
            else begin
              cmd_err <= 1'b1;
              state <= in_tlast ? CMD : DRAIN;
            end
          end
        end
        KEY_RX, BLK_RX: if (acc) begin
          if (state == KEY_RX) key_sh[KEY_S-1-32*cnt -: 32] <= in_tdata;
          else blk_sh[BLK_S-1-32*cnt[1:0] -: 32] <= in_tdata;
          cnt <= cnt + 3'd1;
          if (in_tlast && last_word) begin
            // The final word is still in flight to the shadow, so splice it in directly.
            state <= START;
            in_tready <= 1'b0;
            en_key <= op[0];
            en_cipher <= op[1];
            en_decipher <= op[2];
            if (op[0]) begin
              aes_key <= k256 ? {key_sh[KEY_S-1:32], in_tdata}
                              : {key_sh[KEY_S-1:KEY_S-96], in_tdata, {(KEY_S-128){1'b0}}};
              aes128_mode <= !k256;
              aes256_mode <= k256;
            end else aes_in_blk <= {blk_sh[BLK_S-1:32], in_tdata};
          end else if (in_tlast) begin
            cmd_err <= 1'b1;
            state <= CMD;
          end else if (last_word) begin
            cmd_err <= 1'b1;
            state <= DRAIN;
          end
        end
        START: state <= WAIT_CORE;
        WAIT_CORE: if (en_o) begin
          if (op[0]) begin
            key_valid <= 1'b1;
            in_tready <= 1'b1;
            state <= CMD;
          end else begin
            out_buf <= aes_out_blk << 32;
            out_tdata <= aes_out_blk[BLK_S-1 -: 32];
            out_tvalid <= 1'b1;
            out_tlast <= 1'b0;
            cnt <= '0;
            state <= TX;
          end
        end
        TX: if (out_tready) begin
          cnt <= cnt + 3'd1;
          out_buf <= out_buf << 32;
          out_tdata <= out_buf[BLK_S-1 -: 32];
          out_tlast <= cnt == 3'd2;
          if (out_tlast) begin
            out_tvalid <= 1'b0;
            out_tlast <= 1'b0;
            in_tready <= 1'b1;
            state <= CMD;
          end
        end
        DRAIN: if (acc && in_tlast) state <= CMD;
        default: state <= CMD;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: scoreboard bench with a stand-in invertible core and a packet-level reference model.
module tb_aes_stream_ctrl;
  logic clk = 0, reset = 0;
  logic [31:0] in_tdata = 0, out_tdata;
  logic in_tvalid = 0, in_tready, in_tlast = 0;
  logic out_tvalid, out_tready, out_tlast;
  logic en_cipher, en_decipher, en_key, aes128_mode, aes256_mode, cmd_err, en_o;
  logic [255:0] aes_key;
  logic [127:0] aes_in_blk, aes_out_blk;

  aes_stream_ctrl dut (
    .clk(clk), .reset(reset),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .en_cipher(en_cipher), .en_decipher(en_decipher), .en_key(en_key),
    .aes128_mode(aes128_mode), .aes256_mode(aes256_mode),
    .aes_key(aes_key), .aes_in_blk(aes_in_blk), .aes_out_blk(aes_out_blk),
    .en_o(en_o), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic         k256;
    logic [255:0] key;
    logic [127:0] blk;
  } st_t;

  int total = 0, bad = 0, exp_err = 0, rdy_pct = 10;
  st_t exp_st[$];
  logic [32:0] exp_out[$];
  logic [31:0] pw[16];
  logic key_valid_m = 0, k256_m = 0;
  logic [255:0] key_m = '0;
  localparam logic [127:0] CK = 128'h9e3779b97f4a7c15f39cc0605cedc834;

  // Stand-in cipher: keyed xor plus a constant add, so decrypt exactly undoes encrypt.
  function automatic logic [127:0] mask(input logic [255:0] k);
    return k[255:128] ^ {k[63:0], k[127:64]};
  endfunction
  function automatic logic [127:0] core_fn(input logic dec, input logic [255:0] k, input logic [127:0] b);
    return dec ? (b - CK) ^ mask(k) : (b ^ mask(k)) + CK;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  initial begin
    logic busy;
    int dly;
    logic [127:0] res;
    busy = 0; dly = 0; res = '0; en_o = 0; aes_out_blk = '0;
    forever begin
      @(negedge clk);
      en_o = 0;
      if (!reset) busy = 0;
      else if (busy) begin
        if (dly == 0) begin
          en_o = 1;
          aes_out_blk = res;
          busy = 0;
        end else dly--;
      end else if (en_key || en_cipher || en_decipher) begin
        busy = 1;
        dly = $urandom_range(0, 5);
        res = en_key ? {4{$urandom}} : core_fn(en_decipher, aes_key, aes_in_blk);
      end else if ($urandom_range(0, 15) == 0) begin
        en_o = 1;
        aes_out_blk = {4{$urandom}};
      end
    end
  end

  initial begin
    out_tready = 0;
    forever begin
      @(posedge clk);
      #1 out_tready = ($urandom_range(0, 9) < rdy_pct);
    end
  end

  initial begin
    logic stall_q;
    logic [32:0] held;
    st_t e;
    stall_q = 0; held = '0;
    forever begin
      @(negedge clk);
      if (!reset) stall_q = 0;
      else begin
        if (stall_q) chk("tx_hold", {out_tvalid, out_tlast, out_tdata}, {1'b1, held});
        stall_q = out_tvalid && !out_tready;
        held = {out_tlast, out_tdata};
        if (en_key || en_cipher || en_decipher) begin
          chk("start_expected", exp_st.size() > 0, 1);
          if (exp_st.size() > 0) begin
            e = exp_st.pop_front();
            chk("start_op", {en_decipher, en_cipher, en_key}, e.op);
            chk("key", aes_key, e.key);
            if (e.op == 3'b001) chk("mode", {aes256_mode, aes128_mode}, e.k256 ? 2 : 1);
            else chk("blk", aes_in_blk, e.blk);
          end
        end
        if (cmd_err) begin
          chk("err_expected", exp_err > 0, 1);
          if (exp_err > 0) exp_err--;
        end
        if (out_tvalid && out_tready) begin
          chk("out_expected", exp_out.size() > 0, 1);
          if (exp_out.size() > 0) chk("out_word", {out_tlast, out_tdata}, exp_out.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_tvalid = 0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_tvalid = 1;
      in_tdata = pw[i];
      in_tlast = (i == n - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_tready && t < 400);
      if (!in_tready) begin
        total++;
        bad++;
        $display("FAIL in_tready_wait act=0 exp=1");
      end
      @(posedge clk);
      #1;
    end
    in_tvalid = 0;
    in_tlast = 0;
  endtask

  // Packet-level model: a packet is legal only if its opcode is known, a key exists
  // for block ops, and it carries exactly the expected number of words.
  task automatic do_pkt(input logic [31:0] cmd, input int n);
    logic [3:0] oc;
    logic k2;
    int len;
    logic [255:0] key;
    logic [127:0] blk, r;
    st_t e;
    oc = cmd[3:0];
    k2 = cmd[4];
    len = (oc == 1 && k2) ? 8 : 4;
    pw[0] = cmd;
    if ((oc == 1 || ((oc == 2 || oc == 4) && key_valid_m)) && n == len + 1) begin
      if (oc == 1) begin
        key = '0;
        for (int i = 0; i < len; i++) key[255-32*i -: 32] = pw[i+1];
        e = '{3'b001, k2, key, 128'b0};
        key_m = key;
        k256_m = k2;
        key_valid_m = 1;
      end else begin
        blk = '0;
        for (int i = 0; i < 4; i++) blk[127-32*i -: 32] = pw[i+1];
        e = '{oc[2:0], k256_m, key_m, blk};
        r = core_fn(oc == 4, key_m, blk);
        for (int i = 0; i < 4; i++) exp_out.push_back({i == 3, r[127-32*i -: 32]});
      end
      exp_st.push_back(e);
    end else exp_err++;
    send(n);
  endtask

  task automatic set4(input logic [127:0] v);
    for (int i = 0; i < 4; i++) pw[i+1] = v[127-32*i -: 32];
  endtask
  task automatic set8(input logic [255:0] v);
    for (int i = 0; i < 8; i++) pw[i+1] = v[255-32*i -: 32];
  endtask

  task automatic rand_pkt();
    logic [3:0] oc;
    logic [31:0] cmd;
    int kind, len, n;
    kind = $urandom_range(0, 9);
    if (kind < 3) oc = 4'h1;
    else if (kind < 5) oc = 4'h2;
    else if (kind < 8) oc = 4'h4;
    else do oc = 4'($urandom_range(0, 15)); while (oc == 1 || oc == 2 || oc == 4);
    cmd = $urandom;
    cmd[3:0] = oc;
    len = (oc == 1 && cmd[4]) ? 8 : 4;
    n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 4) : len + 1;
    for (int i = 1; i < 16; i++) pw[i] = $urandom;
    do_pkt(cmd, n);
  endtask

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_tready, 0);
    chk("rst_ctl", {out_tvalid, out_tlast, en_cipher, en_decipher, en_key, aes128_mode, aes256_mode, cmd_err}, 0);
    chk("rst_key", aes_key, 0);
    chk("rst_blk", aes_in_blk, 0);
    chk("rst_tdata", out_tdata, 0);
    @(posedge clk);
    #1 reset = 1;
    set4(PT); do_pkt(32'h2, 5);
    set4(K128); do_pkt(32'h1, 5);
    set4(PT); do_pkt(32'h2, 5);
    set4(core_fn(0, {K128, 128'b0}, PT)); do_pkt(32'h4, 5);
    set8(K256); do_pkt(32'h11, 9);
    set4(PT); do_pkt(32'h2, 5);
    rdy_pct = 4;
    set4(128'h01896745230189674523119178563412); do_pkt(32'h2, 5);
    do_pkt(32'h3, 5);
    set8(~K256); do_pkt(32'h11, 3);
    set4(~PT); pw[5] = 32'hdeadbeef; pw[6] = 32'h12345678; do_pkt(32'h2, 7);
    set4(~PT); do_pkt(32'h4, 5);
    do_pkt(32'h2, 1);
    rdy_pct = 6;
    for (int i = 0; i < 70; i++) rand_pkt();
    if (!key_valid_m) begin
      set4(K128); do_pkt(32'h1, 5);
    end
    set4(PT); do_pkt(32'h2, 5);
    t = 0;
    while (!en_cipher && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rst_test_start_seen", en_cipher, 1);
    @(posedge clk);
    #1 reset = 0;
    exp_out.delete();
    key_valid_m = 0;
    key_m = '0;
    k256_m = 0;
    @(negedge clk);
    chk("midrst_ready", in_tready, 0);
    chk("midrst_ctl", {out_tvalid, out_tlast, en_cipher, en_decipher, en_key, aes128_mode, aes256_mode, cmd_err}, 0);
    chk("midrst_key", aes_key, 0);
    chk("midrst_blk", aes_in_blk, 0);
    chk("midrst_tdata", out_tdata, 0);
    @(posedge clk);
    #1 reset = 1;
    set4(PT); do_pkt(32'h2, 5);
    set4(K128); do_pkt(32'h1, 5);
    set4(PT); do_pkt(32'h4, 5);
    t = 0;
    while ((exp_out.size() > 0 || exp_st.size() > 0 || exp_err > 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk("end_out_left", exp_out.size(), 0);
    chk("end_start_left", exp_st.size(), 0);
    chk("end_err_left", exp_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
